// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts ALU op requests over valid/ready and drives result select,
// adder controls and the bit-serial multiplier sequence.
module alu_op_sequencer #(
   parameter int MUL_CYCLES = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       op_valid,
   input  logic [3:0] op_code,
   output logic       op_ready,
   output logic [2:0] sel,
   output logic       b_invert,
   output logic       carry_in,
   output logic       mul_clear,
   output logic       mul_step,
   output logic       res_valid,
   output logic       illegal
);
   typedef enum logic [2:0] {IDLE, EXEC, ILL, MUL_INIT, MUL_RUN, MUL_DONE} state_t;
   state_t state, state_nx;
   logic [7:0] cnt;
   logic accept, legal, is_mul, dec_inv;
   logic [2:0] dec_sel;
   always_comb begin
      accept  = op_valid && op_ready;
      legal   = op_code < 4'h7;
      is_mul  = op_code == 4'h5;
      dec_sel = op_code == 4'h0 ? 3'b000 :
                op_code == 4'h1 ? 3'b001 :
                (op_code == 4'h2 || op_code == 4'h3) ? 3'b010 :
                op_code == 4'h4 ? 3'b011 :
                op_code == 4'h5 ? 3'b100 : 3'b101;
      dec_inv = op_code == 4'h3 || op_code == 4'h4;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = accept ? (!legal ? ILL : is_mul ? MUL_INIT : EXEC) :
                 state == MUL_INIT ? MUL_RUN :
                 state == MUL_RUN ? (cnt == 8'(MUL_CYCLES - 1) ? MUL_DONE : MUL_RUN) :
                 IDLE;
   end
   always_comb begin
      op_ready  = state != MUL_INIT && state != MUL_RUN;
      res_valid = state == EXEC || state == MUL_DONE;
      mul_clear = state == MUL_INIT;
      mul_step  = state == MUL_RUN;
      illegal   = state == ILL;
   end
   // Decode is latched only for legal accepts so an illegal op leaves the mux untouched.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         sel      <= '0;
         b_invert <= 1'b0;
         carry_in <= 1'b0;
      end else begin
         cnt <= state == MUL_RUN ? cnt + 8'd1 : '0;
         if (accept && legal) begin
            sel      <= dec_sel;
            b_invert <= dec_inv;
            carry_in <= dec_inv;
         end
      end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus with a result scoreboard checked by a separate monitor.
module tb_alu_op_sequencer;
   typedef struct packed {logic ill; logic [2:0] sel; logic bi; logic ci;} exp_t;
   logic clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0;
   logic [3:0] op_code = '0;
   logic op_ready, b_invert, carry_in, mul_clear, mul_step, res_valid, illegal;
   logic [2:0] sel;
   logic v2 = 1'b0;
   logic [3:0] c2 = '0;
   logic r2_ready, r2_binv, r2_cin, r2_clr, r2_step, r2_valid, r2_ill;
   logic [2:0] r2_sel;
   int checks = 0, errors = 0;
   exp_t sb[$];
   alu_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
      .sel(sel), .b_invert(b_invert), .carry_in(carry_in), .mul_clear(mul_clear),
      .mul_step(mul_step), .res_valid(res_valid), .illegal(illegal));
   alu_op_sequencer #(.MUL_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .op_valid(v2), .op_code(c2), .op_ready(r2_ready),
      .sel(r2_sel), .b_invert(r2_binv), .carry_in(r2_cin), .mul_clear(r2_clr),
      .mul_step(r2_step), .res_valid(r2_valid), .illegal(r2_ill));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   function automatic exp_t mk(input logic ill, input logic [2:0] s, input logic b);
      return exp_t'{ill, s, b, b};
   endfunction
   task automatic send(input logic [3:0] op, input logic push, input exp_t e);
      int n = 0;
      op_valid = 1'b1;
      op_code  = op;
      while (!op_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("send_ready", 16'(op_ready), 16'd1);
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (res_valid || illegal) begin
            if (sb.size() == 0) chk("unexpected_result", {res_valid, illegal, sel}, 16'd0);
            else begin
               e = sb.pop_front();
               chk("scoreboard", {res_valid, illegal, sel, b_invert, carry_in},
                   {~e.ill, e.ill, e.sel, e.bi, e.ci});
            end
         end
         if ($countones({res_valid, mul_clear, mul_step, illegal}) > 1)
            chk("exclusive", {res_valid, mul_clear, mul_step, illegal}, 16'd0);
      end
   end
   initial begin
      #3;
      chk("reset_state", {sel, b_invert, carry_in, mul_clear, mul_step, res_valid, illegal, op_ready}, 16'h0001);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;
      send(4'h2, 1'b1, mk(0, 3'b010, 0));
      send(4'h3, 1'b1, mk(0, 3'b010, 1));
      send(4'h4, 1'b1, mk(0, 3'b011, 1));
      send(4'h6, 1'b1, mk(0, 3'b101, 0));
      @(posedge clk); #1;
      // MUL with OR held on the request lines for the whole stall
      send(4'h5, 1'b1, mk(0, 3'b100, 0));
      op_valid = 1'b1;
      op_code  = 4'h1;
      sb.push_back(mk(0, 3'b001, 0));
      chk("mul_clear", {mul_clear, mul_step, op_ready}, 16'b100);
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         chk("mul_step", {mul_clear, mul_step, op_ready}, 16'b010);
      end
      @(posedge clk); #1;
      chk("mul_done", {res_valid, op_ready, mul_step, sel}, 16'b110100);
      @(posedge clk); #1;
      op_valid = 1'b0;
      chk("or_after_mul", {res_valid, sel}, 16'b1001);
      @(posedge clk); #1;
      chk("idle", {res_valid, op_ready}, 16'b01);
      send(4'h6, 1'b1, mk(0, 3'b101, 0));
      send(4'hA, 1'b1, mk(1, 3'b101, 0));
      chk("illegal", {illegal, res_valid, sel}, 16'b10101);
      @(posedge clk); #1;
      chk("illegal_one_cycle", {illegal, res_valid}, 16'b00);
      // abort a multiply during its 10th step
      send(4'h5, 1'b0, mk(0, 3'b100, 0));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
      end
      chk("step10", {mul_step, op_ready}, 16'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_abort", {sel, b_invert, carry_in, mul_clear, mul_step, res_valid, illegal, op_ready}, 16'h0001);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send(4'h0, 1'b1, mk(0, 3'b000, 0));
      chk("and_after_reset", {res_valid, sel}, 16'b1000);
      // short multiply on the MUL_CYCLES=2 instance
      v2 = 1'b1;
      c2 = 4'h5;
      chk("m2_ready", 16'(r2_ready), 16'd1);
      @(posedge clk); #1;
      v2 = 1'b0;
      chk("m2_clear", {r2_clr, r2_step, r2_valid, r2_ready}, 16'b1000);
      @(posedge clk); #1;
      chk("m2_step1", {r2_clr, r2_step, r2_valid, r2_ready}, 16'b0100);
      @(posedge clk); #1;
      chk("m2_step2", {r2_clr, r2_step, r2_valid, r2_ready}, 16'b0100);
      @(posedge clk); #1;
      chk("m2_result", {r2_clr, r2_step, r2_valid, r2_ready, r2_sel}, 16'b0011100);
      @(posedge clk); #1;
      chk("m2_idle", {r2_valid, r2_ready}, 16'b01);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
